spi_reg_peripheral: RTL and testbench
=====================================

Name: spi_reg_peripheral

Overview:
SPI-mode-0 write-only slave that turns serial frames on the chip's dedicated inputs into a small control-register file. It sits directly downstream of the top-level pins (ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS) inside tt_um_uwasic_onboarding_kaleb_lacroix. Its registers feed the PWM/output-enable stage. All logic runs on the system clock; SPI pins are oversampled, never used as clocks.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each pin synchronizer (min 2)
MAX_ADDR, 4, highest valid register address; writes above it are discarded

Ports:
clk  in  1  system clock (10 MHz nominal, at least 4x SCLK)
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock pin, asynchronous to clk
copi  in  1  SPI data-in pin, asynchronous
ncs  in  1  SPI chip select pin, active low, asynchronous
en_reg_out_7_0  out  8  register 0x00, output enables bits 7:0
en_reg_out_15_8  out  8  register 0x01, output enables bits 15:8
en_reg_pwm_7_0  out  8  register 0x02, PWM mode bits 7:0
en_reg_pwm_15_8  out  8  register 0x03, PWM mode bits 15:8
pwm_duty_cycle  out  8  register 0x04, duty value (0x00=0%, 0xFF=100%)

Behaviour:
- Reset: all five outputs 0x00, synchronizers cleared to idle levels (sclk=0, copi=0, ncs=1), FSM IDLE, bit counter 0, shift register 0. Reset is async assert; takes effect mid-frame, discarding the frame.
- Each pin passes through SYNC_STAGES flops; edges detected by comparing last two synchronized samples.
- Frame: 16 bits MSB first, sampled on synchronized SCLK rising edge. Bit 15 = R/W (1=write), bits 14:8 = address, bits 7:0 = data.
- FSM IDLE: wait for synchronized nCS falling edge -> clear counter and shift register, go SHIFT.
- FSM SHIFT: each SCLK rising edge shifts copi into LSB, counter increments, saturating at 17 (17 = overflow marker). On synchronized nCS rising edge -> COMMIT.
- FSM COMMIT (one cycle): if counter==16 and bit15==1 and address<=MAX_ADDR, write data to addressed register; else no change. Always return to IDLE.
- Latency: register updates no later than SYNC_STAGES+2 clk cycles after ncs pin rises.
- Discard cases: fewer than 16 bits, more than 16 bits, read frames (bit15=0), address > MAX_ADDR. Discarded frames leave all registers unchanged.
- SCLK edges while nCS high are ignored. nCS falling edge during SHIFT cannot occur (nCS still low); a re-select after COMMIT starts a fresh frame.
- Simultaneous SCLK rising and nCS rising in the same clk: nCS rising wins, final bit not captured (counts as short frame).
- Outputs are registers; they hold value indefinitely between writes.

Decomposition:
- Shared package spi_reg_pkg: address constants ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04; frame width 16; FSM state enum (IDLE, SHIFT, COMMIT).
- One sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated three times (sclk, copi, ncs; copi uses level only).

Test Plan:
- After reset, no SPI activity -> all five outputs 0x00.
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) at SCLK=clk/10 -> en_reg_out_7_0=0xF0 within 4 clk of ncs rise, others 0x00.
- Writes 0x8280 then 0x8480 -> en_reg_pwm_7_0=0x80, pwm_duty_cycle=0x80; then read frame 0x0455 -> duty stays 0x80.
- Write to addr 0x30 (frame 0xB0AA) -> no register changes; 15-bit frame and 17-bit frame targeting 0x01 -> en_reg_out_15_8 unchanged.
- Assert rst_n low after 8 bits of frame 0x81FF, release, then send 0x8133 -> en_reg_out_15_8=0x33, never 0xFF.
- SCLK toggled 20 times with ncs high, then valid 0x83A5 -> only en_reg_pwm_15_8=0xA5.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI control-register peripheral: register
// map, frame geometry and the frame FSM state type.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    // Bit counter is wide enough to hold the overflow marker one past a full frame.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
    localparam logic [CNT_W-1:0] CNT_OVF  = 5'd17;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle: the bus master drives all three lines, the peripheral only observes.
interface spi_reg_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the last two synchronized samples.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw pin through the synchronizer and remember the previous stable sample.
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain to one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only slave: oversamples the pins on clk, assembles
// 16-bit frames {rw, addr[6:0], data[7:0]} and commits valid writes into
// five control registers on chip-select release.
module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_peripheral_if.slave        spi,
    output logic [7:0]                 en_reg_out_7_0,
    output logic [7:0]                 en_reg_out_15_8,
    output logic [7:0]                 en_reg_pwm_7_0,
    output logic [7:0]                 en_reg_pwm_15_8,
    output logic [7:0]                 pwm_duty_cycle
);

    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi_level, w_copi_rise, w_copi_fall;
    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;

    // Only the sampled data level matters on copi; its edge pulses are deliberately dropped.
    logic w_copi_unused;
    assign w_copi_unused = w_copi_rise | w_copi_fall | w_sclk_level | w_sclk_fall | w_ncs_level;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (spi.sclk),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (spi.copi),
        .o_level (w_copi_level),
        .o_rise  (w_copi_rise),
        .o_fall  (w_copi_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (spi.ncs),
        .o_level (w_ncs_level),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_BITS-1:0]  r_shift;

    logic [6:0] w_addr;
    logic [7:0] w_data;
    logic       w_commit_ok;

    assign w_addr      = r_shift[14:8];
    assign w_data      = r_shift[7:0];
    assign w_commit_ok = (r_cnt == CNT_FULL) && r_shift[15] && (w_addr <= MAX_A);

    // Frame FSM: collect bits while selected, then write the register file in one COMMIT cycle.
    // NOTE: every register here, including the control registers, has an explicit async
    // reset value; nothing is left to power-up state, so a reset mid-frame is always clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_shift         <= '0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect takes priority over a coincident SCLK edge: that last bit is lost.
                    if (w_ncs_rise) begin
                        r_state <= COMMIT;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
                        if (r_cnt != CNT_OVF) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (w_commit_ok) begin
                        case (w_addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= w_data;
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= w_data;
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= w_data;
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= w_data;
                            ADDR_DUTY:      pwm_duty_cycle  <= w_data;
                            default: ;
                        endcase
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: stimulus pushes expected register
// snapshots; a monitor pops and compares them a fixed latency after each
// deselect or explicit check request.
module tb_spi_reg_peripheral;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_reg_peripheral_if spi_bus ();

    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi_bus.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    typedef struct packed {
        logic [7:0] out_lo;
        logic [7:0] out_hi;
        logic [7:0] pwm_lo;
        logic [7:0] pwm_hi;
        logic [7:0] duty;
    } snap_t;

    snap_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    event  chk_ev;
    bit    ff_seen = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [7:0] e);
        snap_t s;
        s = '{out_lo: a, out_hi: b, pwm_lo: c, pwm_hi: d, duty: e};
        exp_q.push_back(s);
    endtask

    // SCLK = clk/10: five clk per half period, data changes while SCLK is low.
    task automatic sel();
        spi_bus.ncs = 1'b0;
        wait_clk(5);
    endtask

    task automatic bits(input logic [31:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_bus.copi = f[i];
            wait_clk(5);
            spi_bus.sclk = 1'b1;
            wait_clk(5);
            spi_bus.sclk = 1'b0;
        end
    endtask

    task automatic desel();
        wait_clk(5);
        spi_bus.ncs  = 1'b1;
        spi_bus.copi = 1'b0;
        wait_clk(12);
    endtask

    task automatic send(input logic [31:0] f, input int n);
        sel();
        bits(f, n);
        desel();
    endtask

    // Monitor: after each deselect (or check request) wait the worst-case update latency, then compare.
    initial begin
        snap_t e;
        @(negedge clk);
        forever begin
            @(posedge spi_bus.ncs or chk_ev);
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty: got an output event, expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("en_reg_out_7_0",  en_reg_out_7_0,  e.out_lo);
                check("en_reg_out_15_8", en_reg_out_15_8, e.out_hi);
                check("en_reg_pwm_7_0",  en_reg_pwm_7_0,  e.pwm_lo);
                check("en_reg_pwm_15_8", en_reg_pwm_15_8, e.pwm_hi);
                check("pwm_duty_cycle",  pwm_duty_cycle,  e.duty);
            end
        end
    end

    // The aborted 0x81FF frame must never leave 0xFF in register 0x01.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && en_reg_out_15_8 === 8'hFF && !ff_seen) begin
            ff_seen = 1'b1;
            n_err++;
            $display("FAIL aborted_frame_leak: got en_reg_out_15_8 0xff, expected never 0xff");
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        rst_n        = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        // Reset state.
        push(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        -> chk_ev;
        wait_clk(10);

        // Basic write to 0x00.
        push(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        send(32'h80F0, 16);

        // PWM enable low byte and duty, then a read frame that must not disturb duty.
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h00);
        send(32'h8280, 16);
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h80);
        send(32'h8480, 16);
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h80);
        send(32'h0455, 16);

        // Out-of-range address, 15-bit short frame, 17-bit long frame to 0x01.
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h80);
        send(32'hB0AA, 16);
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h80);
        send(32'h40AA, 15);
        push(8'hF0, 8'h00, 8'h80, 8'h00, 8'h80);
        send(32'h102AB, 17);

        // Reset asserted after 8 bits of 0x81FF: everything clears, frame is dropped.
        push(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        sel();
        bits(32'h81, 8);
        rst_n = 1'b0;
        wait_clk(2);
        -> chk_ev;
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(5);
        push(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        desel();
        push(8'h00, 8'h33, 8'h00, 8'h00, 8'h00);
        send(32'h8133, 16);

        // SCLK activity while deselected is ignored.
        for (int i = 0; i < 20; i++) begin
            spi_bus.sclk = 1'b1;
            wait_clk(5);
            spi_bus.sclk = 1'b0;
            wait_clk(5);
        end
        push(8'h00, 8'h33, 8'h00, 8'h00, 8'h00);
        -> chk_ev;
        wait_clk(10);
        push(8'h00, 8'h33, 8'h00, 8'hA5, 8'h00);
        send(32'h83A5, 16);

        wait_clk(10);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
